dispatch_controller: RTL
========================

Name: dispatch_controller

Overview:
- Sequences instructions from the instruction queue (IQ) through the combinational decoder into the out-of-order back end.
- Each dispatch allocates one ROB entry and routes the instruction to either the reservation station (RS) or the load/store buffer (LSB).
- Stalls the front end after a JALR until its target is resolved.
- Squashes in-flight issue on rollback and keeps a dispatch counter.

Parameters:
- ROB_ADDR_W, 4, width of the ROB tag.
- XLEN, 32, data, address and instruction width.
- OP_W, 6, width of the decoder op_enum.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; low freezes all registers.
- iq_valid  in  1  IQ head entry is valid.
- iq_inst  in  XLEN  raw instruction at IQ head.
- iq_pc  in  XLEN  PC of IQ head.
- iq_pop  out  1  combinational; consume the IQ head this cycle.
- dec_inst  out  XLEN  drives the decoder input; equals iq_inst.
- dec_op_enum  in  OP_W  decoder op result.
- dec_is_jump  in  1  decoder flag.
- dec_is_load  in  1  decoder flag.
- dec_is_store  in  1  decoder flag.
- rob_full  in  1  no free ROB entry.
- rob_tag  in  ROB_ADDR_W  tag of the next free ROB entry.
- rob_alloc  out  1  combinational; allocate rob_tag this cycle.
- rs_full  in  1  RS cannot accept an issue arriving next cycle.
- lsb_full  in  1  LSB cannot accept an issue arriving next cycle.
- rs_issue  out  1  registered one-cycle issue strobe to RS.
- lsb_issue  out  1  registered one-cycle issue strobe to LSB.
- issue_tag  out  ROB_ADDR_W  registered ROB tag of the issued instruction.
- issue_op  out  OP_W  registered op_enum.
- issue_pc  out  XLEN  registered PC.
- jalr_done  in  1  ROB/ALU reports the outstanding JALR target is resolved.
- rollback  in  1  misprediction flush.
- stall_jalr  out  1  high while in WAIT_JALR.
- dispatch_cnt  out  32  number of dispatched instructions; wraps modulo 2^32.

Behaviour:
- Reset (rst_in high at a clock edge): state=RUN.
  - rs_issue, lsb_issue, stall_jalr = 0.
  - issue_tag, issue_op, issue_pc, dispatch_cnt = 0.
  - Reset takes priority over rdy_in and rollback.
- rdy_in low: all registers hold; iq_pop and rob_alloc are forced 0. Consumers gate the held strobes with rdy_in.
- States:
  - RUN: normal dispatch.
  - WAIT_JALR: a JALR has been dispatched and its target is unresolved.
  - FLUSH: one-cycle drain after rollback.
- Target selection: dec_is_load or dec_is_store goes to LSB; any other valid op goes to RS (including JAL, JALR, branches, LUI, AUIPC).
- Illegal op (dec_op_enum == reset value):
  - iq_pop=1, rob_alloc=0, no issue strobe, dispatch_cnt unchanged.
  - The instruction is dropped.
- fire = rdy_in & state==RUN & !rollback & iq_valid & !rob_full & (target is LSB ? !lsb_full : !rs_full) & op legal.
- On fire, same cycle: iq_pop=1 and rob_alloc=1.
- On fire, next edge:
  - Exactly one of rs_issue/lsb_issue is 1.
  - issue_tag=rob_tag, issue_op=dec_op_enum, issue_pc=iq_pc.
  - dispatch_cnt increments by 1.
- Without fire: rs_issue=lsb_issue=0 at the next edge (strobes last exactly one cycle); issue_tag, issue_op and issue_pc hold.
- Throughput: at most one dispatch per cycle; back-to-back dispatch is allowed.
- JALR (op == JALR) fires normally, then state becomes WAIT_JALR at the next edge.
- WAIT_JALR:
  - No fire.
  - jalr_done=1 sets state to RUN at the next edge; the first new fire can occur in the following cycle.
- rollback=1 (any state, highest priority after reset):
  - No fire that cycle; iq_pop=0, rob_alloc=0.
  - Next edge: rs_issue=lsb_issue=0, state=FLUSH.
  - FLUSH lasts one cycle with no fire, then returns to RUN, unless rollback is high again, in which case state stays FLUSH.
- rollback and jalr_done in the same cycle: rollback wins, state goes to FLUSH.
- A stall from a full ROB or a full target stalls only the IQ head; it does not change state.
- stall_jalr = (state == WAIT_JALR), registered.

Test Plan:
1. Reset, then iq_valid=1, iq_inst=0x00500093 (ADDI), rob_tag=3, all fulls 0 -> iq_pop=rob_alloc=1 same cycle; next cycle rs_issue=1, lsb_issue=0, issue_tag=3, dispatch_cnt=1.
2. iq_inst=0x0000A103 (LW) with lsb_full=1 for 2 cycles, then 0 -> no iq_pop for 2 cycles; pop on 3rd cycle; next cycle lsb_issue=1 only.
3. JALR 0x00008067 followed by ADDI in the IQ -> JALR issues to RS and stall_jalr=1. No pop of the ADDI for 5 cycles. jalr_done pulsed in cycle 5 -> ADDI pops in cycle 6; dispatch_cnt ends at 2.
4. Stream of ADDIs, rollback pulsed in cycle 3 -> no pop in cycle 3 or the FLUSH cycle; strobes are 0 in both; pops resume in cycle 5.
5. iq_inst=0x00000000 (illegal) -> iq_pop=1, rob_alloc=0, no issue strobe, dispatch_cnt unchanged.
6. rdy_in=0 for 3 cycles mid-stream with rob_full=0 -> no pops; all outputs hold their values; dispatch resumes in the first cycle with rdy_in=1.

Source files
------------

// File: rtl/dispatch_controller.sv
// dispatch_controller: moves the IQ head through the decoder into the
// back end, one instruction per cycle, allocating a ROB entry for each.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global enable)
//   iq_valid/iq_inst/iq_pc   : IQ head;  iq_pop consumes it
//   dec_inst                 : decoder input (mirrors iq_inst)
//   dec_op_enum, dec_is_*    : decoder results for the IQ head
//   rob_full/rob_tag         : ROB free-entry status; rob_alloc claims it
//   rs_full/lsb_full         : back-pressure from the issue targets
//   rs_issue/lsb_issue       : one-cycle registered issue strobes
//   issue_tag/op/pc          : registered payload of the last issue
//   jalr_done                : outstanding JALR target resolved
//   rollback                 : misprediction flush
//   stall_jalr               : front end held behind a JALR
//   dispatch_cnt             : dispatched instruction count (wraps)

module dispatch_controller #(
  parameter int ROB_ADDR_W = 4,
  parameter int XLEN       = 32,
  parameter int OP_W       = 6,
  parameter logic [OP_W-1:0] OP_ILLEGAL = '0,
  parameter logic [OP_W-1:0] OP_JALR    = OP_W'(2)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  iq_valid,
  input  logic [XLEN-1:0]       iq_inst,
  input  logic [XLEN-1:0]       iq_pc,
  output logic                  iq_pop,
  output logic [XLEN-1:0]       dec_inst,
  input  logic [OP_W-1:0]       dec_op_enum,
  input  logic                  dec_is_jump,
  input  logic                  dec_is_load,
  input  logic                  dec_is_store,
  input  logic                  rob_full,
  input  logic [ROB_ADDR_W-1:0] rob_tag,
  output logic                  rob_alloc,
  input  logic                  rs_full,
  input  logic                  lsb_full,
  output logic                  rs_issue,
  output logic                  lsb_issue,
  output logic [ROB_ADDR_W-1:0] issue_tag,
  output logic [OP_W-1:0]       issue_op,
  output logic [XLEN-1:0]       issue_pc,
  input  logic                  jalr_done,
  input  logic                  rollback,
  output logic                  stall_jalr,
  output logic [31:0]           dispatch_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_JALR,
    ST_FLUSH
  } state_t;

  state_t state_q;
  state_t state_d;

  logic go_lsb;
  logic op_legal;
  logic is_jalr;
  logic tgt_full;
  logic head_ok;
  logic fire;
  logic drop;

  assign dec_inst = iq_inst;

  always_comb begin
    go_lsb   = dec_is_load | dec_is_store;
    op_legal = (dec_op_enum != OP_ILLEGAL);
    is_jalr  = dec_is_jump & (dec_op_enum == OP_JALR);
    tgt_full = go_lsb ? lsb_full : rs_full;

    // The head may be consumed only while running and not flushing.
    head_ok = rdy_in & (state_q == ST_RUN)
            & ~rollback & iq_valid;

    fire = head_ok & op_legal & ~rob_full & ~tgt_full;

    // Illegal ops leave the IQ without touching the ROB or targets,
    // so back-pressure does not hold them.
    drop = head_ok & ~op_legal;

    iq_pop    = fire | drop;
    rob_alloc = fire;
  end

  always_comb begin
    state_d = state_q;
    if (rollback) begin
      state_d = ST_FLUSH;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (fire && is_jalr) state_d = ST_WAIT_JALR;
        end
        ST_WAIT_JALR: begin
          if (jalr_done) state_d = ST_RUN;
        end
        ST_FLUSH: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_RUN;
      stall_jalr   <= 1'b0;
      rs_issue     <= 1'b0;
      lsb_issue    <= 1'b0;
      issue_tag    <= '0;
      issue_op     <= '0;
      issue_pc     <= '0;
      dispatch_cnt <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      stall_jalr <= (state_d == ST_WAIT_JALR);
      rs_issue   <= fire & ~go_lsb;
      lsb_issue  <= fire & go_lsb;
      if (fire) begin
        issue_tag    <= rob_tag;
        issue_op     <= dec_op_enum;
        issue_pc     <= iq_pc;
        dispatch_cnt <= dispatch_cnt + 32'd1;
      end
    end
  end

endmodule
